text_buffer: RTL and testbench

- Character-cell frame store feeding the VGA text renderer.
- Accepts a byte stream (ASCII plus a few control codes) over a valid/ready handshake and writes glyph codes at a cursor into an 80x60 cell RAM.
- Hardware scroll is a rotating top-row offset, not a memory copy.
- Exposes a read port addressed by the renderer's linear cell address (row*80+col) and returns the glyph code one clock later.

---
 rtl/text_pkg.sv | 35 +++
 rtl/text_buffer_if.sv | 24 ++
 rtl/text_ram.sv | 33 +++
 rtl/text_buffer.sv | 161 ++++++++++++++++
 tb/tb_text_buffer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants, control codes, FSM encoding and the scroll address
// translation used by the text frame store.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 13;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_t;

  // Logical cell address to physical RAM address under the rotating
  // top-row offset. The offset is always < CELLS, so one conditional
  // subtract is enough for any in-range logical address.
  function automatic logic [ADDR_W-1:0] phys(input logic [ADDR_W-1:0] a,
                                              input logic [ADDR_W-1:0] off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, off};
    if (sum >= (ADDR_W+1)'(CELLS)) begin
      sum = sum - (ADDR_W+1)'(CELLS);
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Byte-stream handshake, renderer read port and cursor/status outputs of
// the text frame store. master = byte source / renderer, slave = store.
interface text_buffer_if;
  import text_pkg::*;

  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [5:0]        cur_row;
  logic [6:0]        cur_col;
  logic              busy;

  modport master (
    output char_in, char_valid, rd_addr,
    input  char_ready, rd_data, cur_row, cur_col, busy
  );

  modport slave (
    input  char_in, char_valid, rd_addr,
    output char_ready, rd_data, cur_row, cur_col, busy
  );
endinterface

// File: rtl/text_ram.sv
// Simple dual-port cell RAM: one write port, one registered read port.
// A same-cycle read and write of one cell returns the old contents.
module text_ram
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [CELLS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; the output register clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell frame store: decodes a byte stream into glyph writes at a
// cursor, scrolls by rotating the top-row offset, and serves the renderer
// one glyph per clock through a registered read port.
module text_buffer
  import text_pkg::*;
(
  input logic          clk,
  input logic          reset,
  text_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] TOP_OFF_MAX   = ADDR_W'(CELLS - COLS);
  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
  localparam logic [6:0]        COL_LAST      = 7'(COLS - 1);
  localparam logic [5:0]        ROW_LAST      = 6'(ROWS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] top_off_reg, top_off_next;
  logic [5:0]        row_reg, row_next;
  logic [6:0]        col_reg, col_next;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              do_nl;
  logic [ADDR_W-1:0] cur_lin;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] rd_phys;
  logic [7:0]        rd_q;

  assign cur_lin   = ADDR_W'(row_reg) * COLS_A + ADDR_W'(col_reg);
  // Physical start of the on-screen bottom row under the current offset.
  assign line_base = phys(LAST_ROW_BASE, top_off_reg);
  assign rd_phys   = phys(bus.rd_addr, top_off_reg);

  assign bus.char_ready = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.cur_row    = row_reg;
  assign bus.cur_col    = col_reg;
  assign bus.rd_data    = rd_q;

  text_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_phys),
    .rdata (rd_q)
  );

  // State, cursor, offset and clear-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLR_ALL;
      cnt_reg     <= '0;
      top_off_reg <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      top_off_reg <= top_off_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
    end
  end

  // Byte decode, newline/scroll handling and clear sequencing.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    top_off_next = top_off_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    we           = 1'b0;
    waddr        = cnt_reg;
    wdata        = BLANK;
    do_nl        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.char_valid) begin
          if (bus.char_in >= 8'h20 && bus.char_in <= 8'h7E) begin
            // Glyph goes in with the pre-scroll offset, on the same edge
            // that may advance the offset.
            we    = 1'b1;
            waddr = phys(cur_lin, top_off_reg);
            wdata = bus.char_in;
            if (col_reg == COL_LAST) begin
              col_next = '0;
              do_nl    = 1'b1;
            end else begin
              col_next = col_reg + 7'd1;
            end
          end else begin
            case (bus.char_in)
              CC_CR: col_next = '0;
              CC_LF: do_nl = 1'b1;
              CC_BS: begin
                if (col_reg != '0) begin
                  col_next = col_reg - 7'd1;
                  we       = 1'b1;
                  waddr    = phys(cur_lin - ONE_A, top_off_reg);
                end
              end
              CC_FF: begin
                row_next     = '0;
                col_next     = '0;
                top_off_next = '0;
                cnt_next     = '0;
                state_next   = CLR_ALL;
              end
              default: ;
            endcase
          end

          if (do_nl) begin
            if (row_reg != ROW_LAST) begin
              row_next = row_reg + 6'd1;
            end else begin
              // The old top physical row becomes the new bottom row.
              top_off_next = (top_off_reg == TOP_OFF_MAX) ? '0 : top_off_reg + COLS_A;
              cnt_next     = '0;
              state_next   = CLR_LINE;
            end
          end
        end
      end

      CLR_LINE: begin
        we    = 1'b1;
        waddr = line_base + cnt_reg;
        if (cnt_reg == COLS_A - ONE_A) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + ONE_A;
        end
      end

      CLR_ALL: begin
        we    = 1'b1;
        waddr = cnt_reg;
        if (cnt_reg == LAST_CELL) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + ONE_A;
        end
      end

      default: state_next = CLR_ALL;
    endcase
  end

endmodule

// File: tb/tb_text_buffer.sv
// Randomised scoreboard bench for text_buffer. The reference model is a
// logical 60x80 screen that scrolls by copying rows; the driver pushes the
// expected cursor per byte and expected glyph per read, and a monitor pops
// and compares whenever a byte is accepted or read data is presented.
module tb_text_buffer;
  import text_pkg::*;

  logic clk = 1'b0;
  logic reset;
  text_buffer_if bus ();

  text_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rd_en = 1'b0;
  logic [7:0] scr [ROWS][COLS];
  int         m_row, m_col, m_busy;

  logic [12:0] exp_cur_q[$];
  logic [7:0]  exp_rd_q[$];
  int          exp_addr_q[$];

  logic mon_acc, mon_rdv;
  logic [7:0] mon_byte;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_blank();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = 8'h20;
      m_busy = COLS;
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    m_busy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[m_row][m_col] = b;
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline();
      end else begin
        m_col++;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row][m_col] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      model_blank();
      m_busy = CELLS;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a byte, hold it until accepted; returns the number of extra
  // cycles it had to be held. Ends on the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int waited);
    @(negedge clk);
    rd_en          = 1'b0;
    bus.char_in    = b;
    bus.char_valid = 1'b1;
    model_apply(b);
    exp_cur_q.push_back({6'(m_row), 7'(m_col)});
    waited = 0;
    while (!bus.char_ready && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 6000) chk("accept_timeout", 0, 1);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  // Count remaining busy cycles and compare with the clear length the
  // model expects from the last byte.
  task automatic finish_op();
    int n;
    n = 0;
    while (bus.busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", n, m_busy);
  endtask

  task automatic put(input logic [7:0] b);
    int w;
    send(b, w);
    finish_op();
  endtask

  task automatic read_cell(input int a);
    @(negedge clk);
    bus.rd_addr = ADDR_W'(a);
    rd_en       = 1'b1;
    exp_rd_q.push_back(scr[a / COLS][a % COLS]);
    exp_addr_q.push_back(a);
  endtask

  task automatic rd_stop();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic scan_all();
    for (int a = 0; a < CELLS; a++) read_cell(a);
    rd_stop();
  endtask

  // ---------------- monitor ----------------
  // Capture handshake/read activity at the edge, compare just after it.
  always @(posedge clk) begin
    mon_acc  = bus.char_valid && bus.char_ready && !reset;
    mon_byte = bus.char_in;
    mon_rdv  = rd_en;
    #1;
    if (mon_acc) begin
      $display("byte %02h -> cursor (%0d,%0d)", mon_byte, bus.cur_row, bus.cur_col);
      if (exp_cur_q.size() == 0) begin
        chk("cur_q_underflow", 0, 1);
      end else begin
        logic [12:0] e;
        e = exp_cur_q.pop_front();
        chk("cur_row", int'(bus.cur_row), int'(e[12:7]));
        chk("cur_col", int'(bus.cur_col), int'(e[6:0]));
      end
    end
    if (mon_rdv) begin
      if (exp_rd_q.size() == 0) begin
        chk("rd_q_underflow", 0, 1);
      end else begin
        logic [7:0] ev;
        int ea;
        ev = exp_rd_q.pop_front();
        ea = exp_addr_q.pop_front();
        chk($sformatf("rd_data@%0d", ea), int'(bus.rd_data), int'(ev));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, w, r;
    logic [7:0] b;

    reset          = 1'b1;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.rd_addr    = '0;
    model_blank();
    m_busy = 0;

    repeat (3) @(negedge clk);
    chk("reset_ready", int'(bus.char_ready), 0);
    chk("reset_busy", int'(bus.busy), 1);
    chk("reset_rd_data", int'(bus.rd_data), 0);
    chk("reset_cur_row", int'(bus.cur_row), 0);
    chk("reset_cur_col", int'(bus.cur_col), 0);

    // Power-up clear: ready stays low for one cycle per cell.
    reset = 1'b0;
    n = 0;
    while (!bus.char_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("init_clear_cycles", n, CELLS);
    read_cell(0);
    read_cell(2399);
    read_cell(4799);
    rd_stop();

    // Two printable glyphs.
    put(8'h41);
    put(8'h42);
    read_cell(0);
    read_cell(1);
    read_cell(2);
    rd_stop();

    // Column wrap to the next row.
    put(8'h0C);
    for (int i = 0; i < 79; i++) put(8'h78);
    put(8'h79);
    read_cell(78);
    read_cell(79);
    read_cell(80);
    read_cell(81);
    rd_stop();

    // Scroll off the bottom after 60 CR/LF pairs.
    put(8'h0C);
    put(8'h54);
    for (int i = 0; i < 60; i++) begin
      put(8'h0D);
      put(8'h0A);
    end
    for (int a = 4720; a < CELLS; a++) read_cell(a);
    read_cell(0);
    rd_stop();

    // Backspace at column 0 is a no-op; elsewhere it blanks the cell.
    put(8'h08);
    for (int i = 0; i < 5; i++) put(8'h61 + 8'(i));
    put(8'h08);
    read_cell(4720 + 3);
    read_cell(4720 + 4);
    rd_stop();

    // Form feed held during a line clear: accepted only when ready.
    {b} = 8'h0A;
    send(b, w);
    send(8'h0C, w);
    // One busy cycle elapsed before the FF was presented.
    chk("ff_hold_cycles", w + 1, COLS);
    finish_op();
    scan_all();

    // Random byte stream with many scrolls (offset wraps several times).
    for (int i = 0; i < 1200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 62)      b = 8'($urandom_range(32, 126));
      else if (r < 80) b = 8'h0A;
      else if (r < 88) b = 8'h0D;
      else if (r < 95) b = 8'h08;
      else if (r < 98) b = 8'($urandom_range(128, 255));
      else             b = 8'h1B;
      put(b);
      if (i % 40 == 0) begin
        read_cell(int'($urandom_range(0, CELLS - 1)));
        // Out-of-range address, unchecked; must not disturb anything.
        @(negedge clk);
        rd_en       = 1'b0;
        bus.rd_addr = 13'h1FFF;
        read_cell(m_row * COLS + m_col);
        rd_stop();
      end
    end
    scan_all();

    repeat (3) @(negedge clk);
    chk("cur_q_drained", exp_cur_q.size(), 0);
    chk("rd_q_drained", exp_rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
